mil_link_arbiter: RTL and testbench
===================================

# mil_link_arbiter

Parametrised bus-direction arbiter for the MIL-STD-1553 link layer, serving `CHANNELS` redundant bus channels (A/B by default). It grants one channel to the transmitter at a time and keeps the receivers of all other channels enabled. It enforces a transmit-to-receive turnaround delay and a transmitter hold timeout, and generates the shared Manchester io clock. It also produces per-channel packet start/end strobes for the upstream packet framer.

## Interface
- `CHANNELS`, 2: number of bus channels; must be ≥ 2.
- `IO_DIV`, 50: clk cycles per io_clk half-period.
- `T2R_DELAY`, 12: turnaround length in io ticks.
- `TX_TIMEOUT`, 800: maximum transmit hold in io ticks.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `io_clk` out 1: io clock, period 2·IO_DIV clk cycles.
- `io_tick` out 1: one-cycle strobe marking each io_clk 0→1 transition.
- `channel_enable` in CHANNELS: per-channel enable.
- `rx_busy` in CHANNELS: per-channel receiver busy.
- `tx_request` in 1: transmitter requests the bus; held for the whole transmission.
- `tx_channel` in $clog2(CHANNELS): requested channel; sampled on grant only.
- `tx_grant` out CHANNELS: one-hot transmit grant, or zero.
- `rx_grant` out CHANNELS: per-channel receiver enable.
- `tx_timeout` out 1: one-cycle strobe when a transmit hold is cut off.
- `tx_reject` out 1: one-cycle strobe when a request targets a disabled channel.
- `packet_start` out CHANNELS: one-cycle strobe on each rx_busy 0→1 edge.
- `packet_end` out CHANNELS: one-cycle strobe on each rx_busy 1→0 edge.

## Operation
- **io clock.** Divider counts 0..IO_DIV-1 and wraps. On each wrap, io_clk toggles.
  - io_tick is registered and is high in the same cycle io_clk first reads 1.
  - The divider free-runs regardless of arbiter state.
- **Tick counter.** Saturating, width $clog2(max(T2R_DELAY,TX_TIMEOUT)+1). It increments on io_tick only and clears on every state change.
- **Channel latch.** ch holds the granted channel. It is loaded from tx_channel on the RECEIVE→TRANSMIT transition.
- **RECEIVE.** Outputs: rx_grant = all ones, tx_grant = 0.
  - tx_request=1, channel_enable[tx_channel]=1 and rx_busy[tx_channel]=0: go to TRANSMIT and latch ch.
  - tx_request=1 and channel_enable[tx_channel]=0: pulse tx_reject and go to LOCKOUT.
  - tx_request=1 with rx_busy[tx_channel]=1: stay in RECEIVE; the request stays pending.
- **TRANSMIT.** Outputs: tx_grant = one-hot(ch), rx_grant = all ones except bit ch.
  - rx_busy[ch] is ignored, because it is the transmitter's own echo.
  - tx_request=0: go to WAIT.
  - Counter reaches TX_TIMEOUT with tx_request still 1: pulse tx_timeout and go to LOCKOUT.
- **WAIT.** Outputs: rx_grant = all ones, tx_grant = 0.
  - Counter == T2R_DELAY or rx_busy[ch]=1: go to RECEIVE.
  - tx_request is ignored in this state.
- **LOCKOUT.** Same outputs as WAIT.
  - tx_request=0: go to WAIT, which applies a full turnaround.
- **Packet strobes.** Registered edge detect on rx_busy, independent of state and grants.

## Timing
- **Reset values.** While rst=1 and after release:
  - State RECEIVE; all counters 0; io_clk=0; io_tick=0.
  - tx_grant=0; rx_grant=all ones.
  - tx_timeout, tx_reject, packet_start and packet_end all 0.
- **Edge-detector reset.** During reset the edge-detector history registers load the current rx_busy. As a result, no strobe fires in the first cycle after release.
- **First io_tick.** Counting from the first non-reset edge as cycle 1, io_tick is first high in cycle IO_DIV, then every 2·IO_DIV cycles.
- **Grant latency.**
  - tx_request sampled high at edge n gives tx_grant high from cycle n+1.
  - tx_request sampled low at edge m gives tx_grant low from cycle m+1.
- **Turnaround.** WAIT lasts T2R_DELAY io ticks, i.e. between (T2R_DELAY-1)·2·IO_DIV+1 and T2R_DELAY·2·IO_DIV clk cycles depending on phase. rx_busy[ch] ends it early, one cycle after it is sampled.
- **Strobe latency.** Each packet strobe is high exactly one cycle, in the cycle after the rx_busy edge is sampled.
- **Simultaneous events.**
  - tx_request falls in the same cycle the timeout count is reached: go to WAIT, no tx_timeout.
  - rx_busy[tx_channel] and tx_request rise together in RECEIVE: the receiver wins and the request stays pending.
  - channel_enable drops during TRANSMIT: no effect until the next request.
- **Reset mid-transmit.** tx_grant drops the cycle after rst is sampled. There is no tx_timeout and no turnaround.

## Test plan
- **Grant/release.** Reset, then tx_request=1 with tx_channel=1. Required: tx_grant=2'b10 and rx_grant=2'b01 one cycle later. Drop the request; tx_grant=0 the next cycle and rx_grant=2'b11.
- **Turnaround.** With IO_DIV=4 and T2R_DELAY=3, drop tx_request and hold rx_busy=0. Required: WAIT exits on the third io_tick, within 17..24 cycles. A tx_request asserted during WAIT is granted only after that exit.
- **Early exit.** In WAIT, rx_busy[ch]=1. Required: RECEIVE the next cycle and packet_start[ch]=1 for one cycle.
- **Timeout.** With TX_TIMEOUT=5, hold tx_request. Required: tx_timeout pulses on the 5th io_tick and tx_grant=0. No new grant until tx_request=0 followed by a full WAIT.
- **Reject and busy.** channel_enable=2'b01 with a request on channel 1: required one tx_reject pulse and LOCKOUT. A request on channel 0 while rx_busy[0]=1 is not granted until rx_busy[0]=0.
- **Reset mid-transmit.** Assert rst during TRANSMIT. Required: all outputs at their reset values, io_clk=0, and no packet strobes on release with rx_busy=2'b11.

Source files
------------

// File: rtl/mil_link_arbiter_if.sv
// mil_link_arbiter_if: bus-side signal bundle of the 1553 link arbiter.
// master drives requests and receiver status, slave is the arbiter.
interface mil_link_arbiter_if #(
    parameter int CHANNELS = 2
);
    localparam int CHW = $clog2(CHANNELS);

    logic                io_clk;
    logic                io_tick;
    logic [CHANNELS-1:0] channel_enable;
    logic [CHANNELS-1:0] rx_busy;
    logic                tx_request;
    logic [CHW-1:0]      tx_channel;
    logic [CHANNELS-1:0] tx_grant;
    logic [CHANNELS-1:0] rx_grant;
    logic                tx_timeout;
    logic                tx_reject;
    logic [CHANNELS-1:0] packet_start;
    logic [CHANNELS-1:0] packet_end;

    modport master (
        output channel_enable, rx_busy, tx_request, tx_channel,
        input  io_clk, io_tick, tx_grant, rx_grant,
        input  tx_timeout, tx_reject, packet_start, packet_end
    );

    modport slave (
        input  channel_enable, rx_busy, tx_request, tx_channel,
        output io_clk, io_tick, tx_grant, rx_grant,
        output tx_timeout, tx_reject, packet_start, packet_end
    );
endinterface

// File: rtl/mil_link_arbiter.sv
// mil_link_arbiter: 1553 bus-direction arbiter with turnaround, tx
// hold timeout, shared Manchester io clock and rx packet strobes.
module mil_link_arbiter #(
    parameter int CHANNELS   = 2,
    parameter int IO_DIV     = 50,
    parameter int T2R_DELAY  = 12,
    parameter int TX_TIMEOUT = 800
) (
    input logic               clk,
    input logic               rst,
    mil_link_arbiter_if.slave bus
);
    localparam int CHW  = $clog2(CHANNELS);
    localparam int MAXT = (T2R_DELAY > TX_TIMEOUT) ? T2R_DELAY : TX_TIMEOUT;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int DW   = (IO_DIV > 1) ? $clog2(IO_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(IO_DIV - 1);
    localparam logic [CW-1:0] T2R_LAST = CW'(T2R_DELAY - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RECEIVE,
        S_TRANSMIT,
        S_WAIT,
        S_LOCKOUT
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [DW-1:0]       div_q;
    logic                io_clk_q, io_tick_q;
    logic                timeout_q, timeout_d;
    logic                reject_q, reject_d;
    logic [CHANNELS-1:0] busy_q, start_q, end_q;
    logic [CHANNELS-1:0] tx_grant_c, rx_grant_c;
    logic                req_en, req_busy;
    logic                hit_t2r, hit_to;

    // Free-running io clock divider; tick marks each io_clk rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            io_clk_q  <= 1'b0;
            io_tick_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q     <= '0;
            io_clk_q  <= ~io_clk_q;
            io_tick_q <= ~io_clk_q;
        end else begin
            div_q     <= div_q + 1'b1;
            io_tick_q <= 1'b0;
        end
    end

    // Look up enable/busy of the requested channel; out-of-range reads disabled.
    always_comb begin
        req_en   = 1'b0;
        req_busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.tx_channel == CHW'(i)) begin
                req_en   = bus.channel_enable[i];
                req_busy = bus.rx_busy[i];
            end
        end
    end

    // A limit is reached on the io tick that brings the count up to it.
    assign hit_t2r = io_tick_q && (cnt_q == T2R_LAST);
    assign hit_to  = io_tick_q && (cnt_q == TO_LAST);

    // Arbiter next state, channel latch, strobes and grant decode.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        timeout_d  = 1'b0;
        reject_d   = 1'b0;
        tx_grant_c = '0;
        rx_grant_c = '1;
        unique case (state_q)
            S_RECEIVE: begin
                if (bus.tx_request) begin
                    if (!req_en) begin
                        reject_d = 1'b1;
                        state_d  = S_LOCKOUT;
                    end else if (!req_busy) begin
                        state_d = S_TRANSMIT;
                        ch_d    = bus.tx_channel;
                    end
                end
            end
            S_TRANSMIT: begin
                tx_grant_c[ch_q] = 1'b1;
                rx_grant_c[ch_q] = 1'b0;
                if (!bus.tx_request) begin
                    state_d = S_WAIT;
                end else if (hit_to) begin
                    timeout_d = 1'b1;
                    state_d   = S_LOCKOUT;
                end
            end
            S_WAIT: begin
                if (hit_t2r || bus.rx_busy[ch_q]) state_d = S_RECEIVE;
            end
            S_LOCKOUT: begin
                if (!bus.tx_request) state_d = S_WAIT;
            end
            default: state_d = S_RECEIVE;
        endcase
    end

    // State, latched channel and event strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RECEIVE;
            ch_q      <= '0;
            timeout_q <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            timeout_q <= timeout_d;
            reject_q  <= reject_d;
        end
    end

    // Saturating io-tick counter, restarted on every state change.
    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) begin
            cnt_q <= '0;
        end else if (io_tick_q && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // rx_busy edge detect; history tracks the input during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= bus.rx_busy;
            start_q <= '0;
            end_q   <= '0;
        end else begin
            busy_q  <= bus.rx_busy;
            start_q <= bus.rx_busy & ~busy_q;
            end_q   <= ~bus.rx_busy & busy_q;
        end
    end

    assign bus.io_clk       = io_clk_q;
    assign bus.io_tick      = io_tick_q;
    assign bus.tx_grant     = tx_grant_c;
    assign bus.rx_grant     = rx_grant_c;
    assign bus.tx_timeout   = timeout_q;
    assign bus.tx_reject    = reject_q;
    assign bus.packet_start = start_q;
    assign bus.packet_end   = end_q;
endmodule

// File: tb/tb_mil_link_arbiter.sv
// tb_mil_link_arbiter: directed + random bench for mil_link_arbiter,
// checked every cycle against a tick-counting model of the bus rules.
module tb_mil_link_arbiter;
    localparam int CH  = 2;
    localparam int D   = 4;
    localparam int T2R = 3;
    localparam int TO  = 5;

    typedef enum logic [1:0] {M_RX, M_TX, M_WAIT, M_LOCK} mode_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mil_link_arbiter_if #(.CHANNELS(CH)) bus ();

    mil_link_arbiter #(
        .CHANNELS  (CH),
        .IO_DIV    (D),
        .T2R_DELAY (T2R),
        .TX_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Model state: mode, io ticks spent in it, granted channel, cycle index.
    mode_t       mode;
    mode_t       nm;
    int          ticks;
    int          tt;
    int          k;
    int          gch;
    logic [1:0]  prev_busy;
    logic [1:0]  e_start, e_end;
    logic        e_to, e_rej;
    logic [1:0]  e_txg, e_rxg;
    logic        e_ioc, e_iot;

    function automatic bit tick_at(int c);
        return (c > 0) && ((c % (2 * D)) == D);
    endfunction

    function automatic bit ioclk_at(int c);
        return ((c / D) % 2) == 1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model at each edge, then compare all outputs 1 ns later.
    always @(posedge clk) begin
        if (rst) begin
            mode      = M_RX;
            ticks     = 0;
            k         = 0;
            gch       = 0;
            prev_busy = bus.rx_busy;
            e_to      = 1'b0;
            e_rej     = 1'b0;
            e_start   = 2'b00;
            e_end     = 2'b00;
        end else begin
            tt    = ticks + (tick_at(k) ? 1 : 0);
            nm    = mode;
            e_to  = 1'b0;
            e_rej = 1'b0;
            case (mode)
                M_RX: if (bus.tx_request) begin
                    if (!bus.channel_enable[bus.tx_channel]) begin
                        e_rej = 1'b1;
                        nm    = M_LOCK;
                    end else if (!bus.rx_busy[bus.tx_channel]) begin
                        nm  = M_TX;
                        gch = int'(bus.tx_channel);
                    end
                end
                M_TX: if (!bus.tx_request) nm = M_WAIT;
                      else if (tt == TO) begin
                          e_to = 1'b1;
                          nm   = M_LOCK;
                      end
                M_WAIT: if (tt == T2R || bus.rx_busy[gch]) nm = M_RX;
                default: if (!bus.tx_request) nm = M_WAIT;
            endcase
            ticks     = (nm != mode) ? 0 : tt;
            mode      = nm;
            e_start   = bus.rx_busy & ~prev_busy;
            e_end     = ~bus.rx_busy & prev_busy;
            prev_busy = bus.rx_busy;
            k++;
        end
        e_txg = (mode == M_TX) ? 2'(1 << gch) : 2'b00;
        e_rxg = ~e_txg;
        e_ioc = ioclk_at(k);
        e_iot = tick_at(k);
        #1;
        checks++;
        if (bus.tx_grant !== e_txg || bus.rx_grant !== e_rxg ||
            bus.io_clk !== e_ioc || bus.io_tick !== e_iot ||
            bus.tx_timeout !== e_to || bus.tx_reject !== e_rej ||
            bus.packet_start !== e_start || bus.packet_end !== e_end) begin
            errors++;
            $display("FAIL outputs t=%0t got/exp: txg %b/%b rxg %b/%b clk %b/%b tick %b/%b to %b/%b rej %b/%b ps %b/%b pe %b/%b",
                     $time, bus.tx_grant, e_txg, bus.rx_grant, e_rxg,
                     bus.io_clk, e_ioc, bus.io_tick, e_iot,
                     bus.tx_timeout, e_to, bus.tx_reject, e_rej,
                     bus.packet_start, e_start, bus.packet_end, e_end);
        end
    end

    int n;
    int hits;
    int idx;

    initial begin
        bus.channel_enable = 2'b11;
        bus.rx_busy        = 2'b00;
        bus.tx_request     = 1'b0;
        bus.tx_channel     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_grant", int'(bus.tx_grant), 0);
        chk("reset rx_grant", int'(bus.rx_grant), 3);
        chk("reset io_clk", int'(bus.io_clk), 0);
        rst = 1'b0;

        // grant and release on channel 1
        @(negedge clk);
        bus.tx_request = 1'b1;
        bus.tx_channel = 1'b1;
        @(negedge clk);
        chk("grant tx_grant", int'(bus.tx_grant), 2);
        chk("grant rx_grant", int'(bus.rx_grant), 1);
        bus.tx_request = 1'b0;
        @(negedge clk);
        chk("release tx_grant", int'(bus.tx_grant), 0);
        chk("release rx_grant", int'(bus.rx_grant), 3);

        // turnaround: request during WAIT waits for the exit
        bus.tx_request = 1'b1;
        bus.tx_channel = 1'b0;
        n = 0;
        while (bus.tx_grant == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("turnaround in range", int'(n >= 18 && n <= 25), 1);
        chk("turnaround grant", int'(bus.tx_grant), 1);

        // early WAIT exit on rx_busy of the granted channel
        bus.tx_request = 1'b0;
        @(negedge clk);
        bus.rx_busy = 2'b01;
        @(negedge clk);
        chk("early packet_start", int'(bus.packet_start), 1);
        bus.tx_request = 1'b1;
        bus.tx_channel = 1'b1;
        @(negedge clk);
        chk("early regrant", int'(bus.tx_grant), 2);
        chk("early start width", int'(bus.packet_start), 0);
        bus.rx_busy = 2'b00;

        // transmit hold timeout
        n = 0;
        while (!bus.tx_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout seen", int'(bus.tx_timeout), 1);
        chk("timeout tx_grant", int'(bus.tx_grant), 0);
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_grant != 2'b00) hits++;
        end
        chk("lockout no grant", hits, 0);
        bus.tx_request = 1'b0;
        @(negedge clk);
        bus.tx_request = 1'b1;
        n = 0;
        while (bus.tx_grant == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("post-timeout wait", int'(n >= 18 && n <= 25), 1);
        bus.tx_request = 1'b0;
        repeat (30) @(negedge clk);

        // reject on disabled channel
        bus.channel_enable = 2'b01;
        bus.tx_request     = 1'b1;
        bus.tx_channel     = 1'b1;
        hits = 0;
        n    = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.tx_reject) hits++;
            if (bus.tx_grant != 2'b00) n++;
        end
        chk("reject pulses", hits, 1);
        chk("reject no grant", n, 0);
        bus.tx_request     = 1'b0;
        bus.channel_enable = 2'b11;
        repeat (30) @(negedge clk);

        // busy receiver holds the request pending
        bus.rx_busy    = 2'b01;
        bus.tx_channel = 1'b0;
        bus.tx_request = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.tx_grant != 2'b00) n++;
        end
        chk("busy pending", n, 0);
        bus.rx_busy = 2'b00;
        @(negedge clk);
        chk("busy then grant", int'(bus.tx_grant), 1);

        // reset in the middle of a transmission
        bus.rx_busy = 2'b11;
        rst = 1'b1;
        @(negedge clk);
        chk("rst tx_grant", int'(bus.tx_grant), 0);
        chk("rst rx_grant", int'(bus.rx_grant), 3);
        chk("rst io_clk", int'(bus.io_clk), 0);
        chk("rst tx_timeout", int'(bus.tx_timeout), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst release start", int'(bus.packet_start), 0);
        chk("rst release end", int'(bus.packet_end), 0);
        bus.rx_busy    = 2'b00;
        bus.tx_request = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) bus.tx_request = ~bus.tx_request;
            if ($urandom_range(0, 5) == 0) bus.tx_channel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, 1));
                bus.rx_busy[idx] = ~bus.rx_busy[idx];
            end
            if ($urandom_range(0, 99) == 0) bus.channel_enable = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) bus.channel_enable = 2'b11;
            rst = ($urandom_range(0, 799) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
